uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of cycles to wait for is_transmitting to rise after a load.
REQ-002 SHALL have parameter PRIO_PORT0, default 1, meaning: 1 gives port 0 (command-response path) strict priority; 0 puts all ports in round-robin.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port req, input, 3 bits: per-port send request, held high until the matching ack.
REQ-006 SHALL have ports req_byte0, req_byte1, req_byte2, input, 8 bits each: the byte for each port, stable while its req is high.
REQ-007 SHALL have port ack, output, 3 bits: one-cycle pulse marking that the port's byte was loaded.
REQ-008 SHALL have port transmit, output, 1 bit: one-cycle load strobe to the UART transmitter.
REQ-009 SHALL have port tx_byte, output, 8 bits: the byte presented to the UART transmitter.
REQ-010 SHALL have port is_transmitting, input, 1 bit: UART transmit-line busy flag.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 SHALL have port timeout_err, output, 1 bit: one-cycle pulse when the UART fails to start within TIMEOUT_CYCLES.

Function
REQ-013 SHALL implement states IDLE, WAIT_START and WAIT_END.
REQ-014 In IDLE with any req bit high, SHALL select one winner and, at the next edge, set transmit=1, tx_byte to the winner's byte, ack[winner]=1, and state to WAIT_START.
REQ-015 transmit and ack SHALL each be high for exactly one cycle per load and SHALL be asserted in the same cycle.
REQ-016 tx_byte SHALL hold its value until the next load.
REQ-017 With PRIO_PORT0=1, port 0 SHALL win whenever req[0] is high; ports 1 and 2 SHALL alternate round-robin.
REQ-018 With PRIO_PORT0=0, arbitration SHALL be round-robin over ports 0, 1 and 2.
REQ-019 The round-robin search SHALL begin at the port after the last granted round-robin port.
REQ-020 The round-robin pointer SHALL update only on a grant to a round-robin port.
REQ-021 req SHALL be sampled only in IDLE; req changes in WAIT_START or WAIT_END SHALL have no effect.
REQ-022 In WAIT_START, an 8-bit-wide counter SHALL increment every cycle from 0.
REQ-023 In WAIT_START, is_transmitting=1 SHALL move the state to WAIT_END.
REQ-024 In WAIT_START, if the counter reaches TIMEOUT_CYCLES-1 with is_transmitting=0, the block SHALL pulse timeout_err for one cycle and return to IDLE.
REQ-025 The requester SHALL still receive its ack when a timeout occurs; there SHALL be no retry.
REQ-026 When is_transmitting=1 and the counter reaches TIMEOUT_CYCLES-1 in the same cycle, the block SHALL treat the transmission as started and SHALL NOT raise timeout_err.
REQ-027 In WAIT_END, the block SHALL return to IDLE on the first cycle is_transmitting=0.
REQ-028 The minimum spacing between transmit pulses SHALL be 3 cycles.
REQ-029 The counter SHALL clear on every entry to WAIT_START.
REQ-030 busy SHALL be a combinational decode of state != IDLE.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, transmit=0, tx_byte=0, ack=0, timeout_err=0 and counter=0.
REQ-032 rst_n=0 SHALL immediately set the round-robin pointer so that port 1 is checked first.
REQ-033 Reset asserted mid-transfer SHALL abandon the transfer without emitting an ack or timeout_err.
REQ-034 After rst_n rises, the first grant SHALL occur no earlier than the first rising edge.

Verification
REQ-035 Scenario: req=001, req_byte0=0x05, UART busy for 10 cycles -> transmit=1 and tx_byte=0x05 and ack=001 on one cycle; next load no sooner than 10 cycles later.
REQ-036 Scenario: PRIO_PORT0=1, req=111 held and re-raised after each ack for ports 1 and 2 -> port 0 always wins while req[0] is high; with req[0] low, grants alternate 1, 2, 1, 2.
REQ-037 Scenario: PRIO_PORT0=0, all req held -> grant order 1, 2, 0, 1, 2, 0.
REQ-038 Scenario: is_transmitting stuck at 0 -> exactly one timeout_err pulse 16 cycles after entering WAIT_START, then busy=0 and arbitration resumes.
REQ-039 Scenario: rst_n pulsed low during WAIT_END, req2 high throughout -> outputs zero asynchronously; first post-reset grant goes to port 2 with its byte.
REQ-040 Scenario: is_transmitting rises on cycle 15 of WAIT_START -> no timeout_err; state enters WAIT_END.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Three-port arbiter that feeds a single UART transmitter.
//               Port 0 optionally has strict priority; the remaining ports
//               (or all three) share a round-robin pointer. After each load
//               the block waits for the UART to start and then finish,
//               giving up with a timeout pulse if it never starts.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter bit PRIO_PORT0     = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic [7:0] req_byte0,
    input  logic [7:0] req_byte1,
    input  logic [7:0] req_byte2,
    output logic [2:0] ack,
    output logic       transmit,
    output logic [7:0] tx_byte,
    input  logic       is_transmitting,
    output logic       busy,
    output logic       timeout_err
);

    // Last counter value at which the UART may still be seen starting.
    localparam logic [7:0] C_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        WAIT_END   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_count;
    logic [1:0]  r_rr_last;     // last port granted through round-robin
    logic        w_load;
    logic        w_timeout;
    logic        w_found;
    logic        w_rr_grant;
    logic [1:0]  w_win;
    logic [1:0]  w_idx;
    logic [7:0]  w_win_byte;

    // Modulo-3 increment used to walk the round-robin ring.
    function automatic logic [1:0] next3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Winner selection: optional strict priority for port 0, otherwise a
    // round-robin search starting just after the last round-robin grant.
    always_comb begin
        w_win      = 2'd0;
        w_found    = 1'b0;
        w_rr_grant = 1'b0;
        w_idx      = next3(r_rr_last);
        if (PRIO_PORT0 && req[0]) begin
            w_win   = 2'd0;
            w_found = 1'b1;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!w_found && req[w_idx]) begin
                    w_win      = w_idx;
                    w_found    = 1'b1;
                    w_rr_grant = 1'b1;
                end
                w_idx = next3(w_idx);
            end
        end
    end

    // Byte belonging to the selected port.
    always_comb begin
        case (w_win)
            2'd0:    w_win_byte = req_byte0;
            2'd1:    w_win_byte = req_byte1;
            default: w_win_byte = req_byte2;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; requests are only looked at while idle.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_load      = 1'b1;
                    w_state_nxt = WAIT_START;
                end
            end
            WAIT_START: begin
                // A start seen on the last allowed cycle wins over the timeout.
                if (is_transmitting) begin
                    w_state_nxt = WAIT_END;
                end else if (r_count == C_TO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            WAIT_END: begin
                if (!is_transmitting) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Load strobes, held byte, timeout pulse, start counter and RR pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            transmit    <= 1'b0;
            ack         <= 3'b000;
            tx_byte     <= 8'h00;
            timeout_err <= 1'b0;
            r_count     <= 8'h00;
            r_rr_last   <= 2'd0;   // search after port 0 begins at port 1
        end else begin
            transmit    <= w_load;
            ack         <= w_load ? (3'b001 << w_win) : 3'b000;
            timeout_err <= w_timeout;
            if (w_load) begin
                tx_byte <= w_win_byte;
                r_count <= 8'h00;
            end else if (r_state == WAIT_START) begin
                r_count <= r_count + 8'h01;
            end
            if (w_load && w_rr_grant) begin
                r_rr_last <= w_win;
            end
        end
    end

    assign busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter. Two instances (port 0
//               priority on / off) are exercised one at a time by a
//               transaction-level model of requesters, UART and arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int BIG = 1 << 30;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] req_v [2];
    logic [7:0] byt   [2][3];
    logic       istx  [2];

    logic [2:0] ack0, ack1;
    logic       tx0, tx1, busy0, busy1, to0, to1;
    logic [7:0] txb0, txb1;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.TIMEOUT_CYCLES(16), .PRIO_PORT0(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req_v[0]),
        .req_byte0(byt[0][0]), .req_byte1(byt[0][1]), .req_byte2(byt[0][2]),
        .ack(ack0), .transmit(tx0), .tx_byte(txb0),
        .is_transmitting(istx[0]), .busy(busy0), .timeout_err(to0)
    );

    uart_tx_arbiter #(.TIMEOUT_CYCLES(16), .PRIO_PORT0(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req_v[1]),
        .req_byte0(byt[1][0]), .req_byte1(byt[1][1]), .req_byte2(byt[1][2]),
        .ack(ack1), .transmit(tx1), .tx_byte(txb1),
        .is_transmitting(istx[1]), .busy(busy1), .timeout_err(to1)
    );

    int nvec = 0;
    int nerr = 0;
    int sel  = 0;                 // instance under test
    int cyc  = 0;
    int load_cyc, free_at, to_cyc, win, tx_start, tx_end, rr_last;
    logic [7:0] pend_byte, cur_byte;
    int pol_k, pol_L, fixed_byte;
    int raise_pct [3];
    int glog [$];                 // observed grant ports
    int gcyc [$];                 // observed grant cycles
    int tcnt;                     // observed timeout pulses

    // Spec-level arbitration rule: port 0 first when prioritised, otherwise
    // the first requester found after the last round-robin grant.
    function automatic int pick(logic [2:0] r, bit prio, int last);
        if (prio && r[0]) return 0;
        for (int i = 1; i <= 3; i++) begin
            if (r[(last + i) % 3]) return (last + i) % 3;
        end
        return 0;
    endfunction

    task automatic model_reset();
        load_cyc = -1; free_at = 0; to_cyc = -1;
        tx_start = -1; tx_end = -1; rr_last = 0;
        cur_byte = 8'h00; pend_byte = 8'h00;
        glog.delete(); gcyc.delete(); tcnt = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_v[i] = 3'b000; istx[i] = 1'b0;
            for (int p = 0; p < 3; p++) byt[i][p] = 8'h00;
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle: compare the selected instance with the model, then act as
    // requesters and UART for this cycle and predict the next load.
    task automatic tick();
        logic       o_tx, o_busy, o_to, e_tx, e_busy, e_to;
        logic [2:0] o_ack, e_ack;
        logic [7:0] o_b;
        bit         prio;
        int         k, L;
        @(negedge clk);
        cyc++;
        prio   = (sel == 0);
        o_tx   = sel ? tx1   : tx0;
        o_ack  = sel ? ack1  : ack0;
        o_b    = sel ? txb1  : txb0;
        o_busy = sel ? busy1 : busy0;
        o_to   = sel ? to1   : to0;
        if (cyc == load_cyc) cur_byte = pend_byte;
        e_tx   = (cyc == load_cyc);
        e_ack  = e_tx ? (3'b001 << win) : 3'b000;
        e_busy = (load_cyc >= 0 && cyc >= load_cyc && cyc < free_at);
        e_to   = (cyc == to_cyc);
        nvec++; if (o_tx !== e_tx) begin nerr++; $display("FAIL transmit dut%0d cyc=%0d got %b want %b", sel, cyc, o_tx, e_tx); end
        nvec++; if (o_ack !== e_ack) begin nerr++; $display("FAIL ack dut%0d cyc=%0d got %b want %b", sel, cyc, o_ack, e_ack); end
        nvec++; if (o_b !== cur_byte) begin nerr++; $display("FAIL tx_byte dut%0d cyc=%0d got %h want %h", sel, cyc, o_b, cur_byte); end
        nvec++; if (o_busy !== e_busy) begin nerr++; $display("FAIL busy dut%0d cyc=%0d got %b want %b", sel, cyc, o_busy, e_busy); end
        nvec++; if (o_to !== e_to) begin nerr++; $display("FAIL timeout_err dut%0d cyc=%0d got %b want %b", sel, cyc, o_to, e_to); end
        if (o_tx === 1'b1) begin
            glog.push_back(o_ack == 3'b001 ? 0 : o_ack == 3'b010 ? 1 : o_ack == 3'b100 ? 2 : 3);
            gcyc.push_back(cyc);
        end
        if (o_to === 1'b1) tcnt++;
        if (cyc == load_cyc) begin
            req_v[sel][win] = 1'b0;
            k = (pol_k >= 0) ? pol_k : (($urandom_range(9) == 0) ? 99 : int'($urandom_range(15)));
            L = (pol_L > 0) ? pol_L : int'($urandom_range(4, 1));
            if (k > 15) begin
                tx_start = -1; tx_end = -1;
                free_at = cyc + 16; to_cyc = cyc + 16;
            end else begin
                tx_start = cyc + k; tx_end = tx_start + L; free_at = tx_end + 1;
            end
        end
        for (int p = 0; p < 3; p++) begin
            if (!req_v[sel][p] && int'($urandom_range(99)) < raise_pct[p]) begin
                byt[sel][p]  = (fixed_byte >= 0) ? 8'(fixed_byte) : 8'($urandom);
                req_v[sel][p] = 1'b1;
            end
        end
        istx[sel] = (tx_start >= 0 && cyc >= tx_start && cyc < tx_end);
        if (rst_n && cyc >= free_at && req_v[sel] != 3'b000) begin
            win = pick(req_v[sel], prio, rr_last);
            if (!(prio && req_v[sel][0])) rr_last = win;
            pend_byte = byt[sel][win];
            load_cyc  = cyc + 1;
            free_at   = BIG;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        nvec++; if ({tx0, ack0, txb0, to0, busy0} !== 14'h0) begin nerr++; $display("FAIL reset_dut0 got %h want 0", {tx0, ack0, txb0, to0, busy0}); end
        nvec++; if ({tx1, ack1, txb1, to1, busy1} !== 14'h0) begin nerr++; $display("FAIL reset_dut1 got %h want 0", {tx1, ack1, txb1, to1, busy1}); end
    endtask

    task automatic test_single();
        sel = 0; do_reset();
        pol_k = 0; pol_L = 10; fixed_byte = 8'h05; raise_pct = '{100, 0, 0};
        repeat (30) tick();
        nvec++; if (glog.size() < 2 || glog[0] != 0) begin nerr++; $display("FAIL single_grant got n=%0d port=%0d want n>=2 port=0", glog.size(), glog.size() ? glog[0] : -1); end
        nvec++; if (gcyc.size() < 2 || gcyc[1] - gcyc[0] != 12) begin nerr++; $display("FAIL single_spacing got %0d want 12", gcyc.size() >= 2 ? gcyc[1] - gcyc[0] : -1); end
        nvec++; if (txb0 !== 8'h05) begin nerr++; $display("FAIL single_byte got %h want 05", txb0); end
        fixed_byte = -1;
    endtask

    task automatic test_prio();
        int j;
        sel = 0; do_reset();
        pol_k = 0; pol_L = 1; raise_pct = '{100, 100, 100};
        repeat (20) tick();
        nvec++; if (glog.size() < 5) begin nerr++; $display("FAIL prio_count got %0d want >=5", glog.size()); end
        foreach (glog[i]) begin
            nvec++; if (glog[i] != 0) begin nerr++; $display("FAIL prio_port0 idx=%0d got %0d want 0", i, glog[i]); end
        end
        glog.delete(); raise_pct[0] = 0;
        repeat (20) tick();
        j = (glog.size() > 0 && glog[0] == 0) ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (glog.size() <= j + i || glog[j + i] != ((i % 2) ? 2 : 1)) begin
                nerr++; $display("FAIL prio_rr idx=%0d got %0d want %0d", i, glog.size() > j + i ? glog[j + i] : -1, (i % 2) ? 2 : 1);
            end
        end
    endtask

    task automatic test_round_robin();
        int exp_order [6] = '{1, 2, 0, 1, 2, 0};
        sel = 1; do_reset();
        pol_k = 0; pol_L = 1; raise_pct = '{100, 100, 100};
        repeat (22) tick();
        for (int i = 0; i < 6; i++) begin
            nvec++;
            if (glog.size() <= i || glog[i] != exp_order[i]) begin
                nerr++; $display("FAIL rr_order idx=%0d got %0d want %0d", i, glog.size() > i ? glog[i] : -1, exp_order[i]);
            end
        end
    endtask

    task automatic test_timeout();
        sel = 0; do_reset();
        pol_k = 99; pol_L = 1; raise_pct = '{0, 100, 0};
        tick(); raise_pct = '{0, 0, 0};
        repeat (20) tick();
        nvec++; if (tcnt != 1) begin nerr++; $display("FAIL timeout_count got %0d want 1", tcnt); end
        pol_k = 0; pol_L = 2; raise_pct = '{0, 0, 100};
        tick(); raise_pct = '{0, 0, 0};
        repeat (8) tick();
        nvec++; if (glog.size() != 2 || glog[1] != 2) begin nerr++; $display("FAIL timeout_resume got n=%0d want n=2 port=2", glog.size()); end
    endtask

    task automatic test_boundary();
        sel = 0; do_reset();
        pol_k = 15; pol_L = 2; raise_pct = '{100, 0, 0};
        tick(); raise_pct = '{0, 0, 0};
        repeat (22) tick();
        nvec++; if (tcnt != 0) begin nerr++; $display("FAIL late_start_timeout got %0d want 0", tcnt); end
        nvec++; if (glog.size() != 1) begin nerr++; $display("FAIL late_start_grants got %0d want 1", glog.size()); end
    endtask

    task automatic test_reset_mid();
        bit hit = 1'b0;
        sel = 0; do_reset();
        pol_k = 0; pol_L = 10; raise_pct = '{0, 0, 100};
        for (int i = 0; i < 30 && !hit; i++) begin
            tick();
            hit = (tx_start >= 0 && cyc > tx_start + 1 && cyc < tx_end - 1);
        end
        nvec++; if (!hit) begin nerr++; $display("FAIL reset_mid_reach got 0 want 1"); end
        #2 rst_n = 1'b0;
        #1;
        nvec++; if ({tx0, ack0, txb0, to0, busy0} !== 14'h0) begin nerr++; $display("FAIL reset_mid_async got %h want 0", {tx0, ack0, txb0, to0, busy0}); end
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) tick();
        nvec++; if (glog.size() != 1 || glog[0] != 2) begin nerr++; $display("FAIL reset_mid_grant got n=%0d port=%0d want n=1 port=2", glog.size(), glog.size() ? glog[0] : -1); end
    endtask

    task automatic test_random();
        for (int s = 0; s < 2; s++) begin
            sel = s; do_reset();
            pol_k = -1; pol_L = -1; raise_pct = '{25, 25, 25};
            repeat (1500) tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_v[i] = 3'b000; istx[i] = 1'b0;
            for (int p = 0; p < 3; p++) byt[i][p] = 8'h00;
        end
        pol_k = 0; pol_L = 1; fixed_byte = -1; raise_pct = '{0, 0, 0};
        test_reset();
        test_single();
        test_prio();
        test_round_robin();
        test_timeout();
        test_boundary();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
